// File: rtl/id_ex_buffer.sv
// ID/EX pipeline register with load-use hazard detection and memory-stall hold.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   inValid              decode slot holds a real instruction
//   inSrc1/2, inUse1/2   decode source addresses and their read-enables
//   inDst                decode destination register
//   inData1/2, inImm     register-file operands, sign-extended immediate
//   inAluOp              ALU operation code
//   inWb, inMemRead,
//   inMemWrite           decode control bits
//   flush                branch-taken squash request
//   memStall             memory stage busy, whole pipe frozen
//   sourceAddress1/2     registered sources, to the forwarding unit
//   addressExecute       registered destination
//   data1, data2, imm    registered operands
//   aluOp                registered ALU op
//   wbExecute, memReadExecute, memWriteExecute, validExecute
//                        registered control bits
//   stallDecode          hold PC and IF/ID this cycle (combinational)
//   bubbleCount          saturating count of inserted bubbles
module id_ex_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    input  logic [2:0]  inSrc1,
    input  logic [2:0]  inSrc2,
    input  logic        inUse1,
    input  logic        inUse2,
    input  logic [2:0]  inDst,
    input  logic [15:0] inData1,
    input  logic [15:0] inData2,
    input  logic [15:0] inImm,
    input  logic [3:0]  inAluOp,
    input  logic        inWb,
    input  logic        inMemRead,
    input  logic        inMemWrite,
    input  logic        flush,
    input  logic        memStall,
    output logic [2:0]  sourceAddress1,
    output logic [2:0]  sourceAddress2,
    output logic [2:0]  addressExecute,
    output logic [15:0] data1,
    output logic [15:0] data2,
    output logic [15:0] imm,
    output logic [3:0]  aluOp,
    output logic        wbExecute,
    output logic        memReadExecute,
    output logic        memWriteExecute,
    output logic        validExecute,
    output logic        stallDecode,
    output logic [7:0]  bubbleCount
);

    typedef enum logic {StRun, StHold} state_e;

    typedef struct packed {
        logic [2:0]  src1;
        logic [2:0]  src2;
        logic [2:0]  dst;
        logic [15:0] data1;
        logic [15:0] data2;
        logic [15:0] imm;
        logic [3:0]  alu_op;
        logic        wb;
        logic        mem_read;
        logic        mem_write;
        logic        valid;
    } ex_t;

    state_e     state_q, state_d;
    logic       pending_q, pending_d;
    ex_t        ex_q, ex_d, ex_load;
    logic [7:0] count_q, count_d;
    logic       count_inc;
    logic       hazard;

    // A load in EX whose destination is read by the instruction in decode.
    assign hazard = ex_q.valid & ex_q.mem_read & ex_q.wb & inValid &
                    ((inUse1 & (inSrc1 == ex_q.dst)) | (inUse2 & (inSrc2 == ex_q.dst)));

    always_comb begin
        ex_load.src1      = inSrc1;
        ex_load.src2      = inSrc2;
        ex_load.dst       = inDst;
        ex_load.data1     = inData1;
        ex_load.data2     = inData2;
        ex_load.imm       = inImm;
        ex_load.alu_op    = inAluOp;
        ex_load.wb        = inWb;
        ex_load.mem_read  = inMemRead;
        ex_load.mem_write = inMemWrite;
        ex_load.valid     = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ex_d      = ex_q;
        count_inc = 1'b0;
        unique case (state_q)
            StRun: begin
                if (memStall) begin
                    state_d = StHold;
                    if (flush) pending_d = 1'b1;
                end else if (flush | pending_q) begin
                    // Only squashing a real instruction counts as a bubble.
                    ex_d      = '0;
                    pending_d = 1'b0;
                    count_inc = ex_q.valid;
                end else if (hazard) begin
                    ex_d      = '0;
                    count_inc = 1'b1;
                end else if (inValid) begin
                    ex_d = ex_load;
                end else begin
                    ex_d = '0;
                end
            end
            StHold: begin
                if (flush) pending_d = 1'b1;
                // Leaving HOLD spends one edge without loading.
                if (!memStall) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
        count_d = (count_inc && (count_q != 8'hFF)) ? count_q + 8'd1 : count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            pending_q <= 1'b0;
            ex_q      <= '0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ex_q      <= ex_d;
            count_q   <= count_d;
        end
    end

    assign stallDecode = memStall | (state_q == StHold) |
                         (hazard & ~flush & ~pending_q & (state_q == StRun));

    assign sourceAddress1  = ex_q.src1;
    assign sourceAddress2  = ex_q.src2;
    assign addressExecute  = ex_q.dst;
    assign data1           = ex_q.data1;
    assign data2           = ex_q.data2;
    assign imm             = ex_q.imm;
    assign aluOp           = ex_q.alu_op;
    assign wbExecute       = ex_q.wb;
    assign memReadExecute  = ex_q.mem_read;
    assign memWriteExecute = ex_q.mem_write;
    assign validExecute    = ex_q.valid;
    assign bubbleCount     = count_q;

endmodule

// File: tb/tb_id_ex_buffer.sv
// Self-checking bench for id_ex_buffer: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
module tb_id_ex_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inValid, inUse1, inUse2, inWb, inMemRead, inMemWrite, flush, memStall;
    logic [2:0]  inSrc1, inSrc2, inDst;
    logic [15:0] inData1, inData2, inImm;
    logic [3:0]  inAluOp;
    logic [2:0]  sourceAddress1, sourceAddress2, addressExecute;
    logic [15:0] data1, data2, imm;
    logic [3:0]  aluOp;
    logic        wbExecute, memReadExecute, memWriteExecute, validExecute, stallDecode;
    logic [7:0]  bubbleCount;

    id_ex_buffer dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inSrc1(inSrc1), .inSrc2(inSrc2),
        .inUse1(inUse1), .inUse2(inUse2), .inDst(inDst), .inData1(inData1),
        .inData2(inData2), .inImm(inImm), .inAluOp(inAluOp), .inWb(inWb),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite), .flush(flush), .memStall(memStall),
        .sourceAddress1(sourceAddress1), .sourceAddress2(sourceAddress2),
        .addressExecute(addressExecute), .data1(data1), .data2(data2), .imm(imm),
        .aluOp(aluOp), .wbExecute(wbExecute), .memReadExecute(memReadExecute),
        .memWriteExecute(memWriteExecute), .validExecute(validExecute),
        .stallDecode(stallDecode), .bubbleCount(bubbleCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: contents of the EX slot, whether the pipe is frozen,
    // a remembered flush, and the bubble tally.
    typedef struct {
        logic [2:0]  s1, s2, dst;
        logic [15:0] d1, d2, im;
        logic [3:0]  op;
        logic        wb, mr, mw, v;
    } slot_t;

    slot_t  m_ex;
    bit     m_frozen;
    bit     m_pend;
    int     m_bubbles;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s.s1 = 0; s.s2 = 0; s.dst = 0; s.d1 = 0; s.d2 = 0; s.im = 0; s.op = 0;
        s.wb = 0; s.mr = 0; s.mw = 0; s.v = 0;
        return s;
    endfunction

    function automatic bit model_hazard();
        return m_ex.v && m_ex.mr && m_ex.wb && inValid &&
               ((inUse1 && inSrc1 == m_ex.dst) || (inUse2 && inSrc2 == m_ex.dst));
    endfunction

    function automatic void bump();
        if (m_bubbles < 255) m_bubbles++;
    endfunction

    task automatic check_outputs();
        check("src1", {29'd0, sourceAddress1}, {29'd0, m_ex.s1});
        check("src2", {29'd0, sourceAddress2}, {29'd0, m_ex.s2});
        check("dst", {29'd0, addressExecute}, {29'd0, m_ex.dst});
        check("data1", {16'd0, data1}, {16'd0, m_ex.d1});
        check("data2", {16'd0, data2}, {16'd0, m_ex.d2});
        check("imm", {16'd0, imm}, {16'd0, m_ex.im});
        check("aluop", {28'd0, aluOp}, {28'd0, m_ex.op});
        check("ctrl", {28'd0, wbExecute, memReadExecute, memWriteExecute, validExecute},
              {28'd0, m_ex.wb, m_ex.mr, m_ex.mw, m_ex.v});
        check("bubbles", {24'd0, bubbleCount}, m_bubbles);
    endtask

    // One clock: check the combinational stall, step the model, check registers.
    task automatic cycle();
        bit    hz, exp_stall;
        slot_t nxt;
        #1;
        hz = model_hazard();
        exp_stall = memStall || m_frozen || (!m_frozen && hz && !flush && !m_pend);
        check("stall", {31'd0, stallDecode}, {31'd0, exp_stall});
        nxt = m_ex;
        if (m_frozen) begin
            if (flush) m_pend = 1;
            if (!memStall) m_frozen = 0;
        end else if (memStall) begin
            m_frozen = 1;
            if (flush) m_pend = 1;
        end else if (flush || m_pend) begin
            if (m_ex.v) bump();
            nxt = empty_slot();
            m_pend = 0;
        end else if (hz) begin
            bump();
            nxt = empty_slot();
        end else if (inValid) begin
            nxt.s1 = inSrc1; nxt.s2 = inSrc2; nxt.dst = inDst;
            nxt.d1 = inData1; nxt.d2 = inData2; nxt.im = inImm; nxt.op = inAluOp;
            nxt.wb = inWb; nxt.mr = inMemRead; nxt.mw = inMemWrite; nxt.v = 1;
        end else begin
            nxt = empty_slot();
        end
        @(posedge clk);
        #1;
        m_ex = nxt;
        check_outputs();
    endtask

    task automatic clr_in();
        inValid = 0; inSrc1 = 0; inSrc2 = 0; inUse1 = 0; inUse2 = 0; inDst = 0;
        inData1 = 0; inData2 = 0; inImm = 0; inAluOp = 0; inWb = 0; inMemRead = 0;
        inMemWrite = 0; flush = 0; memStall = 0;
    endtask

    task automatic set_instr(input logic [2:0] s1, input logic u1, input logic [2:0] dst,
                             input logic wb, input logic mr, input logic [15:0] d1);
        inValid = 1; inSrc1 = s1; inUse1 = u1; inSrc2 = 3'd0; inUse2 = 0; inDst = dst;
        inWb = wb; inMemRead = mr; inMemWrite = 0; inData1 = d1; inData2 = 16'h1234;
        inImm = 16'hFFF0; inAluOp = 4'd3;
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        m_ex = empty_slot(); m_frozen = 0; m_pend = 0; m_bubbles = 0;
        check_outputs();
        check("rst_stall", {31'd0, stallDecode}, {31'd0, memStall});
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        clr_in();
        m_ex = empty_slot(); m_frozen = 0; m_pend = 0; m_bubbles = 0;
        #3;
        check_outputs();
        @(negedge clk);
        rst = 1;

        // Load-use: one bubble, then the consumer enters EX.
        set_instr(3'd0, 0, 3'd5, 1, 1, 16'h0);
        cycle();
        set_instr(3'd5, 1, 3'd2, 1, 0, 16'h0);
        #1 check("lu_stall", {31'd0, stallDecode}, 32'd1);
        cycle();
        check("lu_bubble", {31'd0, validExecute}, 32'd0);
        cycle();
        check("lu_src1", {29'd0, sourceAddress1}, 32'd5);
        check("lu_count", {24'd0, bubbleCount}, 32'd1);

        // Same pair but the consumer ignores src1: no stall.
        do_reset();
        clr_in();
        set_instr(3'd0, 0, 3'd5, 1, 1, 16'h0);
        cycle();
        set_instr(3'd5, 0, 3'd2, 1, 0, 16'h0);
        #1 check("nouse_stall", {31'd0, stallDecode}, 32'd0);
        cycle();
        check("nouse_dst", {29'd0, addressExecute}, 32'd2);
        check("nouse_count", {24'd0, bubbleCount}, 32'd0);

        // Memory stall freezes the register for the whole stall plus one edge.
        do_reset();
        clr_in();
        set_instr(3'd1, 1, 3'd3, 1, 0, 16'hF0F0);
        cycle();
        inData1 = 16'hFFFF;
        memStall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("ms_stall", {31'd0, stallDecode}, 32'd1);
            cycle();
            check("ms_hold", {16'd0, data1}, 32'hF0F0);
        end
        memStall = 0;
        cycle();
        check("ms_release", {16'd0, data1}, 32'hF0F0);
        cycle();
        check("ms_load", {16'd0, data1}, 32'hFFFF);

        // Flush during a stall is remembered and applied after the stall.
        do_reset();
        clr_in();
        set_instr(3'd1, 1, 3'd3, 1, 0, 16'h0101);
        cycle();
        memStall = 1; flush = 1;
        cycle();
        flush = 0;
        cycle();
        memStall = 0;
        cycle();
        check("pf_held", {31'd0, validExecute}, 32'd1);
        cycle();
        check("pf_bubble", {31'd0, validExecute}, 32'd0);
        check("pf_count", {24'd0, bubbleCount}, 32'd1);
        cycle();
        check("pf_cleared", {31'd0, validExecute}, 32'd1);

        // Saturation of the bubble counter.
        do_reset();
        clr_in();
        for (int i = 0; i < 261; i++) begin
            set_instr(3'd0, 0, 3'd4, 1, 1, 16'h0);
            cycle();
            set_instr(3'd4, 1, 3'd1, 1, 0, 16'h0);
            cycle();
        end
        check("sat_count", {24'd0, bubbleCount}, 32'd255);

        // Asynchronous reset with a live entry and the memory stage busy.
        clr_in();
        set_instr(3'd2, 1, 3'd7, 1, 0, 16'hAAAA);
        cycle();
        check("ar_valid", {31'd0, validExecute}, 32'd1);
        check("ar_dst", {29'd0, addressExecute}, 32'd7);
        memStall = 1;
        do_reset();
        memStall = 0;
        #1 check("ar_stall0", {31'd0, stallDecode}, 32'd0);

        // Randomized traffic, narrow register range to provoke hazards.
        clr_in();
        for (int n = 0; n < 3000; n++) begin
            inValid    = ($urandom_range(0, 9) < 8);
            inSrc1     = 3'($urandom_range(0, 3));
            inSrc2     = 3'($urandom_range(0, 3));
            inUse1     = 1'($urandom);
            inUse2     = 1'($urandom);
            inDst      = 3'($urandom_range(0, 3));
            inData1    = 16'($urandom);
            inData2    = 16'($urandom);
            inImm      = 16'($urandom);
            inAluOp    = 4'($urandom);
            inWb       = ($urandom_range(0, 9) < 7);
            inMemRead  = 1'($urandom);
            inMemWrite = 1'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            memStall   = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_ex_buffer.md
ID_EX_BUFFER -- requirements
Module: id_ex_buffer

Interface
REQ-001 The block SHALL have these ports (name direction width meaning):
 clk  input  1  single clock, all state updates on rising edge
 rst  input  1  asynchronous active-low reset
 inValid  input  1  decode slot holds a real instruction
 inSrc1, inSrc2  input  3 each  decode source register addresses
 inUse1, inUse2  input  1 each  instruction actually reads inSrc1 / inSrc2
 inDst  input  3  decode destination register
 inData1, inData2  input  16 each  register-file read values
 inImm  input  16  sign-extended immediate
 inAluOp  input  4  ALU operation code
 inWb, inMemRead, inMemWrite  input  1 each  decode control bits
 flush  input  1  branch-taken squash request
 memStall  input  1  memory stage busy, whole pipe frozen
 sourceAddress1, sourceAddress2  output  3 each  registered sources, to forwarding unit
 addressExecute  output  3  registered destination
 data1, data2, imm  output  16 each  registered operands
 aluOp  output  4  registered ALU op
 wbExecute, memReadExecute, memWriteExecute, validExecute  output  1 each  registered controls
 stallDecode  output  1  hold PC and IF/ID this cycle (combinational)
 bubbleCount  output  8  saturating count of inserted bubbles

Function
REQ-002 Every registered output SHALL update only on rising clk, one-cycle latency from inputs.
REQ-003 hazard SHALL be 1 when validExecute & memReadExecute & wbExecute & inValid & ((inUse1 & inSrc1==addressExecute) | (inUse2 & inSrc2==addressExecute)).
REQ-004 A "bubble" SHALL mean: validExecute, wbExecute, memReadExecute, memWriteExecute, aluOp loaded 0; address/data fields loaded 0.
REQ-005 State SHALL be RUN or HOLD plus one pendingFlush flag.
REQ-006 In RUN with memStall=1: state→HOLD, all output registers keep value, pendingFlush set if flush=1.
REQ-007 In HOLD: registers keep value; flush=1 sets pendingFlush; memStall=0 returns to RUN on that edge without loading.
REQ-008 In RUN with memStall=0, priority per edge: (a) flush|pendingFlush → bubble, pendingFlush cleared; (b) else hazard → bubble; (c) else inValid → load all in* fields; (d) else bubble.
REQ-009 stallDecode SHALL equal memStall | (state==HOLD) | (hazard & ~flush & ~pendingFlush & state==RUN).
REQ-010 Only one bubble SHALL be inserted per load-use pair; after the bubble the load has left the register so hazard clears.
REQ-011 bubbleCount SHALL increment by 1 on each edge taking case (b) or (a) with a prior valid entry, saturating at 255, never wrapping.
REQ-012 Simultaneous flush and hazard SHALL resolve as flush; stallDecode=0 in that cycle.
REQ-013 Case (d) bubbles (inValid=0) SHALL NOT count.

Reset
REQ-014 rst low SHALL immediately clear all registered outputs to 0, state→RUN, pendingFlush→0, bubbleCount→0, regardless of clk.
REQ-015 Reset asserted mid-HOLD or mid-hazard SHALL discard the held instruction; first edge after release behaves as RUN with empty register.

Verification
REQ-016 Load r5 (inMemRead=1, inWb=1, inDst=5) then add reading inSrc1=5, inUse1=1 → stallDecode=1 for one cycle, next edge validExecute=0, following edge sourceAddress1=5, bubbleCount=1.
REQ-017 Same as REQ-016 but inUse1=0 → no stall, add loads on next edge, bubbleCount=0.
REQ-018 inData1=16'hF0F0, memStall=1 for 3 cycles while inData1 changes to 16'hFFFF → data1 stays F0F0, stallDecode=1 all 3 cycles, loads FFFF on first edge after memStall=0 plus one.
REQ-019 flush pulse during memStall → after memStall drops, register becomes bubble (validExecute=0), pendingFlush cleared, bubbleCount+1.
REQ-020 Force 260 load-use hazards → bubbleCount=255 and holds.
REQ-021 Assert rst low asynchronously between edges with validExecute=1, addressExecute=3'b111 → outputs 0 immediately, stallDecode=memStall only.
